// File: rtl/syn_lb_master.sv
`timescale 1ns/1ps
// Local-bus master: one command in flight, single-cycle strobes, one response per command.
// Write rsp 2 cycles after accept, read rsp at slave latency + 2; rsp held until rsp_ready, cmd_ready only in IDLE.
module syn_lb_master #(
  parameter int P_LB_DWIDTH = 32,
  parameter int P_LB_AWIDTH = 16,
  parameter int P_TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [P_LB_AWIDTH-1:0] cmd_addr,
  input  logic [P_LB_DWIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_wr,
  output logic [P_LB_DWIDTH-1:0] rsp_data,
  output logic                   rsp_err,
  output logic [P_LB_AWIDTH-1:0] lb_addr,
  output logic                   lb_rd_en,
  output logic                   lb_wr_en,
  output logic [P_LB_DWIDTH-1:0] lb_wr_data,
  input  logic [P_LB_DWIDTH-1:0] lb_rd_data,
  input  logic                   lb_rd_valid,
  output logic [7:0]             stray_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RSP
  } state_t;

  localparam logic [15:0] LP_TMAX = 16'(P_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [P_LB_AWIDTH-1:0] addr_q, addr_d;
  logic [P_LB_DWIDTH-1:0] wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [P_LB_DWIDTH-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [7:0]             stray_q, stray_d;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stray_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stray_q <= stray_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    stray_d   = stray_q;
    cmd_ready = 1'b0;
    lb_rd_en  = 1'b0;
    lb_wr_en  = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wr_d    = cmd_wr;
          state_d = cmd_wr ? S_WR : S_RD_REQ;
        end
      end
      S_WR: begin
        lb_wr_en = 1'b1;
        rdata_d  = '0;
        err_d    = 1'b0;
        state_d  = S_RSP;
      end
      S_RD_REQ: begin
        lb_rd_en = 1'b1;
        cnt_d    = '0;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // Data arriving on the last allowed cycle still counts as a good read.
        if (lb_rd_valid) begin
          rdata_d = lb_rd_data;
          err_d   = 1'b0;
          state_d = S_RSP;
        end else if (cnt_q == LP_TMAX) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (lb_rd_valid && (state_q != S_RD_WAIT) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  assign rsp_wr     = wr_q;
  assign rsp_data   = rdata_q;
  assign rsp_err    = err_q;
  assign lb_addr    = addr_q;
  assign lb_wr_data = wdata_q;
  assign stray_cnt  = stray_q;

endmodule

// File: tb/tb_syn_lb_master.sv
`timescale 1ns/1ps
// Directed bench for syn_lb_master with an 8-cycle read timeout.
module tb_syn_lb_master;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [15:0] lb_addr;
  logic        lb_rd_en;
  logic        lb_wr_en;
  logic [31:0] lb_wr_data;
  logic [31:0] lb_rd_data;
  logic        lb_rd_valid;
  logic [7:0]  stray_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  syn_lb_master #(.P_LB_DWIDTH(32), .P_LB_AWIDTH(16), .P_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_wr     (rsp_wr),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .lb_addr    (lb_addr),
    .lb_rd_en   (lb_rd_en),
    .lb_wr_en   (lb_wr_en),
    .lb_wr_data (lb_wr_data),
    .lb_rd_data (lb_rd_data),
    .lb_rd_valid(lb_rd_valid),
    .stray_cnt  (stray_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Each cycle is observed and driven 1ns after its opening rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: cmd_ready=%b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; lb_rd_data = '0; lb_rd_valid = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
    n_checks++;
    if ({cmd_ready, rsp_valid, lb_rd_en, lb_wr_en, rsp_wr, rsp_err} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: {rdy,rvld,rd,wr,rwr,err}=%b want 100000",
               {cmd_ready, rsp_valid, lb_rd_en, lb_wr_en, rsp_wr, rsp_err});
    end
    n_checks++;
    if ({lb_addr, lb_wr_data, rsp_data, stray_cnt} !== 88'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h stray=%0d want all 0",
               lb_addr, lb_wr_data, rsp_data, stray_cnt);
    end
  endtask

  task automatic test_write();
    rsp_ready = 1'b1;
    accept(1'b1, 16'h0010, 32'hA5A5_1234);
    n_checks++;
    if ({lb_wr_en, lb_rd_en, rsp_valid, cmd_ready, lb_addr, lb_wr_data} !== {4'b1000, 16'h0010, 32'hA5A5_1234}) begin
      n_fail++;
      $display("FAIL write_t1: wr=%b rd=%b rvld=%b rdy=%b addr=%h wdata=%h want 1000 0010 a5a51234",
               lb_wr_en, lb_rd_en, rsp_valid, cmd_ready, lb_addr, lb_wr_data);
    end
    tick();
    n_checks++;
    if ({lb_wr_en, rsp_valid, rsp_wr, rsp_err, cmd_ready, rsp_data} !== {5'b01100, 32'h0}) begin
      n_fail++;
      $display("FAIL write_t2: wr=%b rvld=%b rwr=%b err=%b rdy=%b data=%h want 01100 0",
               lb_wr_en, rsp_valid, rsp_wr, rsp_err, cmd_ready, rsp_data);
    end
    tick();
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL write_t3: rdy=%b rvld=%b want 10", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_read();
    rsp_ready = 1'b1;
    accept(1'b0, 16'h0200, 32'hFFFF_FFFF);
    n_checks++;
    if ({lb_rd_en, lb_wr_en, lb_addr} !== {2'b10, 16'h0200}) begin
      n_fail++;
      $display("FAIL read_t1: rd=%b wr=%b addr=%h want 10 0200", lb_rd_en, lb_wr_en, lb_addr);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      if (k == 4) begin
        lb_rd_valid = 1'b1;
        lb_rd_data  = 32'hCAFE_F00D;
      end
      n_checks++;
      if ({lb_rd_en, lb_wr_en, rsp_valid, cmd_ready, lb_addr} !== {4'b0000, 16'h0200}) begin
        n_fail++;
        $display("FAIL read_wait t%0d: rd=%b wr=%b rvld=%b rdy=%b addr=%h want 0000 0200",
                 k, lb_rd_en, lb_wr_en, rsp_valid, cmd_ready, lb_addr);
      end
    end
    tick();
    lb_rd_valid = 1'b0;
    lb_rd_data  = '0;
    n_checks++;
    if ({rsp_valid, rsp_wr, rsp_err, rsp_data} !== {3'b100, 32'hCAFE_F00D}) begin
      n_fail++;
      $display("FAIL read_t5: rvld=%b rwr=%b err=%b data=%h want 100 cafef00d",
               rsp_valid, rsp_wr, rsp_err, rsp_data);
    end
    tick();
    n_checks++;
    if ({cmd_ready, rsp_valid, stray_cnt} !== {2'b10, 8'd0}) begin
      n_fail++;
      $display("FAIL read_t6: rdy=%b rvld=%b stray=%0d want 10 0", cmd_ready, rsp_valid, stray_cnt);
    end
  endtask

  task automatic test_timeout();
    rsp_ready = 1'b0;
    accept(1'b0, 16'h0300, 32'h0);
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (k < 10) begin
        n_checks++;
        if ({rsp_valid, lb_rd_en} !== 2'b00) begin
          n_fail++;
          $display("FAIL timeout_wait t%0d: rvld=%b rd=%b want 00", k, rsp_valid, lb_rd_en);
        end
      end
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_wr, rsp_data} !== {3'b110, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_t10: rvld=%b err=%b rwr=%b data=%h want 110 0",
               rsp_valid, rsp_err, rsp_wr, rsp_data);
    end
    tick();
    tick();
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'hDEAD_BEEF;
    tick();
    lb_rd_valid = 1'b0;
    lb_rd_data  = '0;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data, stray_cnt} !== {2'b11, 32'h0, 8'd1}) begin
      n_fail++;
      $display("FAIL timeout_stray: rvld=%b err=%b data=%h stray=%0d want 11 0 1",
               rsp_valid, rsp_err, rsp_data, stray_cnt);
    end
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_done: rdy=%b rvld=%b want 10", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_tie();
    rsp_ready = 1'b1;
    accept(1'b0, 16'h0404, 32'h0);
    for (int k = 2; k <= 9; k++) tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_t9: rvld=%b want 0", rsp_valid);
    end
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'h0000_0001;
    tick();
    lb_rd_valid = 1'b0;
    lb_rd_data  = '0;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data, stray_cnt} !== {2'b10, 32'h1, 8'd1}) begin
      n_fail++;
      $display("FAIL tie_t10: rvld=%b err=%b data=%h stray=%0d want 10 1 1",
               rsp_valid, rsp_err, rsp_data, stray_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    accept(1'b0, 16'h0ABC, 32'h0);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 16'h0044;
    cmd_wdata = 32'h0000_55AA;
    tick();
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'h1234_5678;
    tick();
    lb_rd_valid = 1'b0;
    lb_rd_data  = '0;
    for (int k = 3; k <= 7; k++) begin
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_wr, cmd_ready, rsp_data} !== {4'b1000, 32'h1234_5678}) begin
        n_fail++;
        $display("FAIL bp_hold t%0d: rvld=%b err=%b rwr=%b rdy=%b data=%h want 1000 12345678",
                 k, rsp_valid, rsp_err, rsp_wr, cmd_ready, rsp_data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if ({cmd_ready, rsp_valid, lb_wr_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL bp_accept: rdy=%b rvld=%b wr=%b want 100", cmd_ready, rsp_valid, lb_wr_en);
    end
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if ({lb_wr_en, lb_rd_en, lb_addr, lb_wr_data} !== {2'b10, 16'h0044, 32'h0000_55AA}) begin
      n_fail++;
      $display("FAIL bp_next_wr: wr=%b rd=%b addr=%h wdata=%h want 10 0044 000055aa",
               lb_wr_en, lb_rd_en, lb_addr, lb_wr_data);
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_wr, rsp_err, rsp_data} !== {3'b110, 32'h0}) begin
      n_fail++;
      $display("FAIL bp_next_rsp: rvld=%b rwr=%b err=%b data=%h want 110 0",
               rsp_valid, rsp_wr, rsp_err, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    rsp_ready = 1'b1;
    accept(1'b0, 16'h0777, 32'h0);
    tick();
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    n_checks++;
    if ({cmd_ready, rsp_valid, lb_rd_en, lb_wr_en, rsp_err, lb_addr, rsp_data, stray_cnt} !==
        {5'b10000, 16'h0, 32'h0, 8'd0}) begin
      n_fail++;
      $display("FAIL midrst: rdy=%b rvld=%b rd=%b wr=%b err=%b addr=%h data=%h stray=%0d want 10000 0 0 0",
               cmd_ready, rsp_valid, lb_rd_en, lb_wr_en, rsp_err, lb_addr, rsp_data, stray_cnt);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL midrst_idle c%0d: rvld=%b rdy=%b want 01", k, rsp_valid, cmd_ready);
      end
    end
  endtask

  task automatic test_stray_saturation();
    for (int i = 0; i < 300; i++) begin
      if (i == 100) begin
        n_checks++;
        if (stray_cnt !== 8'd100) begin
          n_fail++;
          $display("FAIL stray_mid: stray=%0d want 100", stray_cnt);
        end
      end
      lb_rd_valid = 1'b1;
      lb_rd_data  = 32'h0BAD_0000 | 32'(i);
      tick();
    end
    lb_rd_valid = 1'b0;
    lb_rd_data  = '0;
    n_checks++;
    if ({stray_cnt, rsp_valid, cmd_ready, rsp_data} !== {8'd255, 2'b01, 32'h0}) begin
      n_fail++;
      $display("FAIL stray_sat: stray=%0d rvld=%b rdy=%b data=%h want 255 0 1 0",
               stray_cnt, rsp_valid, cmd_ready, rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_tie();
    test_back_to_back();
    test_reset_mid_read();
    test_stray_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
